// File: rtl/scan_reg_bank.sv
// scan_reg_bank: WIDTH-bit register with functional parallel load, synchronous
// set/reset, and a serial scan chain. A scan shift moves exactly WIDTH bits.
// Bits leave LSB-first on scan_out and enter MSB-first from scan_in.
//
// Optional feature: define SCAN_REG_BANK_CAPTURE_EN to add a CAPTURE state.
// That state loads d into the register for one cycle before the shift starts.
// Without the macro, the shift begins on the current register contents.
//
// Priority on every edge, highest first: rst, set, shift/capture sequencing,
// functional load.

module scan_reg_bank #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic                    flop_clk,
   input  logic                    rst,
   input  logic                    set,
   input  logic [WIDTH-1:0]        d,
   input  logic                    load,
   input  logic                    shift_start,
   input  logic                    scan_in,
   output logic                    scan_out,
   output logic [WIDTH-1:0]        q,
   output logic                    shift_busy,
   output logic                    shift_done
);

   // The counter needs room to represent WIDTH itself, so it never wraps
   // while the shift is in progress.
   localparam int unsigned         CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SCAN_REG_BANK_CAPTURE_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;
`endif

   state_t                         state_q;
   state_t                         state_d;
   logic [CNT_W-1:0]               cnt_q;
   logic [CNT_W-1:0]               cnt_d;
   logic [WIDTH-1:0]               data_q;
   logic [WIDTH-1:0]               data_d;

   // Next-state logic: set overrides the sequencer, and load only acts in IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;

      if (set) begin
         // Set aborts any shift in progress and returns to IDLE without
         // passing through DONE, so no shift_done pulse is produced.
         data_d  = '1;
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // shift_start wins over load; the load data is discarded.
               if (shift_start) begin
                  cnt_d   = '0;
`ifdef SCAN_REG_BANK_CAPTURE_EN
                  state_d = ST_CAPTURE;
`else
                  state_d = ST_SHIFT;
`endif
               end else if (load) begin
                  data_d  = d;
               end
            end

`ifdef SCAN_REG_BANK_CAPTURE_EN
            ST_CAPTURE: begin
               data_d  = d;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
`endif

            ST_SHIFT: begin
               data_d = {scan_in, data_q[WIDTH-1:1]};
               cnt_d  = cnt_q + CNT_W'(1);
               // The comparison uses >= so that a corrupted count still
               // terminates the shift rather than looping round.
               if (cnt_q >= CNT_LAST) begin
                  state_d = ST_DONE;
               end
            end

            ST_DONE: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State register: synchronous reset overrides every other input.
   always_ff @(posedge flop_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Outputs are decoded directly from the registered state, so they never
   // depend combinationally on the inputs.
   always_comb begin
      q          = data_q;
      scan_out   = data_q[0];
      shift_done = (state_q == ST_DONE);
`ifdef SCAN_REG_BANK_CAPTURE_EN
      shift_busy = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE);
`else
      shift_busy = (state_q == ST_SHIFT);
`endif
   end

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed testbench for scan_reg_bank, using WIDTH=8 and RESET_VAL=8'h3C.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at
// the same point.
// Define SCAN_REG_BANK_CAPTURE_EN to run the capture scenario. Without it, the
// direct-shift scenarios run instead.

module tb_scan_reg_bank;

   logic       flop_clk = 1'b0;
   logic       rst = 1'b0;
   logic       set = 1'b0;
   logic [7:0] d = 8'h00;
   logic       load = 1'b0;
   logic       shift_start = 1'b0;
   logic       scan_in = 1'b0;
   logic       scan_out;
   logic [7:0] q;
   logic       shift_busy;
   logic       shift_done;

   int checks = 0;
   int failures = 0;

   scan_reg_bank #(.WIDTH(8), .RESET_VAL(8'h3C)) dut (
      .flop_clk   (flop_clk),
      .rst        (rst),
      .set        (set),
      .d          (d),
      .load       (load),
      .shift_start(shift_start),
      .scan_in    (scan_in),
      .scan_out   (scan_out),
      .q          (q),
      .shift_busy (shift_busy),
      .shift_done (shift_done)
   );

   // Free-running clock with a 10-unit period.
   always #5 flop_clk = ~flop_clk;

   // Advance one rising edge, then settle 1 unit before driving or sampling.
   task automatic step();
      @(posedge flop_clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; set = 1'b1; load = 1'b1; d = 8'hFF; shift_start = 1'b1; scan_in = 1'b1;
      step();
      rst = 1'b0; set = 1'b0; load = 1'b0; d = 8'h00; shift_start = 1'b0; scan_in = 1'b0;
      checks++; if (q !== 8'h3C) begin failures++; $display("[TB] FAIL reset_q got=%h exp=%h", q, 8'h3C); end
      checks++; if (scan_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_scan_out got=%b exp=0", scan_out); end
      checks++; if (shift_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", shift_busy); end
      checks++; if (shift_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", shift_done); end
   endtask

   task automatic test_load();
      load = 1'b1; d = 8'hA5;
      step();
      checks++; if (q !== 8'hA5) begin failures++; $display("[TB] FAIL load_q got=%h exp=%h", q, 8'hA5); end
      load = 1'b0; d = 8'h00;
      step();
      checks++; if (q !== 8'hA5) begin failures++; $display("[TB] FAIL hold_q got=%h exp=%h", q, 8'hA5); end
   endtask

   task automatic test_priority();
      // rst beats set
      rst = 1'b1; set = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (q !== 8'h3C) begin failures++; $display("[TB] FAIL rst_over_set got=%h exp=%h", q, 8'h3C); end
      // set beats load
      load = 1'b1; d = 8'h12;
      step();
      set = 1'b0; load = 1'b0;
      checks++; if (q !== 8'hFF) begin failures++; $display("[TB] FAIL set_over_load got=%h exp=%h", q, 8'hFF); end
   endtask

`ifndef SCAN_REG_BANK_CAPTURE_EN
   task automatic test_shift();
      logic [7:0] exp_bits;
      exp_bits = 8'hA5;
      load = 1'b1; d = 8'hA5;
      step();
      load = 1'b0;
      shift_start = 1'b1; scan_in = 1'b1;
      step();
      shift_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (scan_out !== exp_bits[i] || shift_busy !== 1'b1 || shift_done !== 1'b0) begin
            failures++; $display("[TB] FAIL shift_bit%0d got so=%b busy=%b done=%b exp so=%b busy=1 done=0", i, scan_out, shift_busy, shift_done, exp_bits[i]);
         end
         step();
      end
      checks++; if (shift_done !== 1'b1 || shift_busy !== 1'b0) begin failures++; $display("[TB] FAIL shift_done_edge9 got done=%b busy=%b exp done=1 busy=0", shift_done, shift_busy); end
      checks++; if (q !== 8'hFF) begin failures++; $display("[TB] FAIL shift_final_q got=%h exp=%h", q, 8'hFF); end
      step();
      checks++; if (shift_done !== 1'b0) begin failures++; $display("[TB] FAIL shift_done_one_cycle got=%b exp=0", shift_done); end
   endtask

   task automatic test_start_with_load();
      load = 1'b1; d = 8'hA5;
      step();
      d = 8'h00; shift_start = 1'b1; scan_in = 1'b1;
      step();
      load = 1'b0; shift_start = 1'b0;
      checks++; if (q !== 8'hA5 || shift_busy !== 1'b1) begin failures++; $display("[TB] FAIL start_beats_load got q=%h busy=%b exp q=a5 busy=1", q, shift_busy); end
      for (int i = 0; i < 9; i++) step();
   endtask

   task automatic test_back_to_back();
      logic seen_done;
      load = 1'b1; d = 8'h5A;
      step();
      load = 1'b0;
      shift_start = 1'b1; scan_in = 1'b1;
      step();
      shift_start = 1'b0;
      for (int i = 0; i < 3; i++) step();
      load = 1'b1; d = 8'h00; shift_start = 1'b1;
      step();
      load = 1'b0; shift_start = 1'b0;
      checks++; if (q !== 8'hF5 || shift_busy !== 1'b1) begin failures++; $display("[TB] FAIL midshift_ignore got q=%h busy=%b exp q=f5 busy=1", q, shift_busy); end
      for (int i = 0; i < 4; i++) step();
      checks++; if (shift_done !== 1'b1 || q !== 8'hFF) begin failures++; $display("[TB] FAIL midshift_on_schedule got done=%b q=%h exp done=1 q=ff", shift_done, q); end
      step();
      // second shift, aborted by reset
      shift_start = 1'b1; scan_in = 1'b0;
      step();
      shift_start = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (q !== 8'h3C || scan_out !== 1'b0) begin failures++; $display("[TB] FAIL rst_abort_q got q=%h so=%b exp q=3c so=0", q, scan_out); end
      checks++; if (shift_busy !== 1'b0 || shift_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_abort_flags got busy=%b done=%b exp 0 0", shift_busy, shift_done); end
      seen_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (shift_done !== 1'b0) seen_done = 1'b1;
         step();
      end
      checks++; if (seen_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_abort_no_done got=%b exp=0", seen_done); end
   endtask
`endif

   task automatic test_set_abort();
      logic seen_done;
      load = 1'b1; d = 8'hA5;
      step();
      load = 1'b0;
      shift_start = 1'b1; scan_in = 1'b0;
      step();
      shift_start = 1'b0;
      step(); step();
      set = 1'b1;
      step();
      set = 1'b0;
      checks++; if (q !== 8'hFF) begin failures++; $display("[TB] FAIL set_abort_q got=%h exp=%h", q, 8'hFF); end
      checks++; if (shift_busy !== 1'b0 || shift_done !== 1'b0) begin failures++; $display("[TB] FAIL set_abort_flags got busy=%b done=%b exp 0 0", shift_busy, shift_done); end
      seen_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (shift_done !== 1'b0 || shift_busy !== 1'b0) seen_done = 1'b1;
         step();
      end
      checks++; if (seen_done !== 1'b0) begin failures++; $display("[TB] FAIL set_abort_quiet got=%b exp=0", seen_done); end
      load = 1'b1; d = 8'h12;
      step();
      load = 1'b0;
      checks++; if (q !== 8'h12) begin failures++; $display("[TB] FAIL set_back_to_idle got=%h exp=%h", q, 8'h12); end
   endtask

`ifdef SCAN_REG_BANK_CAPTURE_EN
   task automatic test_capture();
      logic [7:0] exp_bits;
      exp_bits = 8'h81;
      load = 1'b1; d = 8'h00;
      step();
      load = 1'b0;
      d = 8'h81; shift_start = 1'b1; scan_in = 1'b0;
      step();
      shift_start = 1'b0;
      checks++; if (q !== 8'h00 || shift_busy !== 1'b1) begin failures++; $display("[TB] FAIL capture_state got q=%h busy=%b exp q=00 busy=1", q, shift_busy); end
      step();
      checks++; if (q !== 8'h81) begin failures++; $display("[TB] FAIL capture_load got=%h exp=%h", q, 8'h81); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (scan_out !== exp_bits[i] || shift_done !== 1'b0) begin
            failures++; $display("[TB] FAIL capture_bit%0d got so=%b done=%b exp so=%b done=0", i, scan_out, shift_done, exp_bits[i]);
         end
         step();
      end
      checks++; if (shift_done !== 1'b1 || q !== 8'h00) begin failures++; $display("[TB] FAIL capture_done_edge10 got done=%b q=%h exp done=1 q=00", shift_done, q); end
      step();
      checks++; if (shift_done !== 1'b0) begin failures++; $display("[TB] FAIL capture_done_one_cycle got=%b exp=0", shift_done); end
   endtask
`endif

   // Watchdog so a stalled run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Runs every scenario in sequence, then prints the summary.
   initial begin
      test_reset();
      test_load();
`ifndef SCAN_REG_BANK_CAPTURE_EN
      test_shift();
      test_start_with_load();
      test_back_to_back();
`else
      test_capture();
`endif
      test_set_abort();
      test_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
